// File: rtl/barrett_arb_2539_pkg.sv
// -----------------------------------------------------------------------------
// barrett_2539_pkg
// Shared constants and types for the modulo-2539 reduction service.
//   Q      : modulus 2539
//   MU, K  : Barrett constant floor(2^24 / Q) and the half-shift (2*K = 24)
//   Q_SQ   : Q*Q, the upper bound of the exact-reduction operand range
//   DIN_W  : operand width, DOUT_W : residue width, PROD_W : internal width
// -----------------------------------------------------------------------------
package barrett_2539_pkg;

    localparam int DIN_W  = 23;
    localparam int DOUT_W = 12;
    localparam int K      = 12;
    localparam int PROD_W = 24;

    localparam logic [11:0] Q    = 12'd2539;
    localparam logic [12:0] MU   = 13'd6607;
    localparam logic [22:0] Q_SQ = 23'd6446521;

    typedef logic [DIN_W-1:0]  operand_t;
    typedef logic [DOUT_W-1:0] residue_t;

endpackage

// File: rtl/barrett_arb_2539_if.sv
// -----------------------------------------------------------------------------
// barrett_arb_2539_if
// Request/response bundle between the requesters plus downstream consumer
// (master side) and the reduction service (slave side).
//   req_valid [NREQ]      : per-requester operand valid
//   req_data  [NREQ*23]   : packed operands, requester i at [23*i +: 23]
//   req_ready [NREQ]      : per-requester accept, one-hot or zero
//   rsp_valid / rsp_ready : residue handshake
//   rsp_data  [12]        : residue 0..2538
//   rsp_id    [IDW]       : requester index of the residue
// -----------------------------------------------------------------------------
interface barrett_arb_2539_if
    import barrett_2539_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DIN_W-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    residue_t              rsp_data;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/barrett_pipe_2539.sv
// -----------------------------------------------------------------------------
// barrett_pipe_2539
// Three-stage Barrett reduction datapath (x mod 2539) with a valid bit and a
// requester-id sideband carried alongside each operand.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global advance; when low every stage holds
//   in_valid, in_data, in_id    : operand entering S1
//   out_valid, out_data, out_id : S3 contents (residue, id)
// -----------------------------------------------------------------------------
module barrett_pipe_2539
    import barrett_2539_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           in_valid,
    input  operand_t       in_data,
    input  logic [IDW-1:0] in_id,
    output logic           out_valid,
    output residue_t       out_data,
    output logic [IDW-1:0] out_id
);

    localparam logic [PROD_W-1:0] Q_EXT = PROD_W'(Q);

    logic           v1, v2, v3;
    operand_t       op1, op2;
    logic [IDW-1:0] id1, id2, id3;
    logic [11:0]    t2;
    residue_t       res3;

    logic [PROD_W-1:0] prod;
    logic [11:0]       t_next;
    logic [PROD_W-1:0] tq, r0, r1, r2;
    residue_t          res_next;

    // Quotient estimate t = ((x >> K) * MU) >> K; it never exceeds floor(x/Q),
    // so the remainder below is never negative.
    always_comb begin
        prod   = PROD_W'(op1[DIN_W-1:K]) * PROD_W'(MU);
        t_next = 12'(prod >> K);
    end

    // Remainder estimate lies in [0, 3Q) for in-range operands, so two
    // conditional subtractions are enough to land in [0, Q).
    always_comb begin
        tq       = PROD_W'(t2) * Q_EXT;
        r0       = PROD_W'(op2) - tq;
        r1       = (r0 >= Q_EXT) ? (r0 - Q_EXT) : r0;
        r2       = (r1 >= Q_EXT) ? (r1 - Q_EXT) : r1;
        res_next = DOUT_W'(r2);
    end

    // All stages shift together; a stall freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            op1  <= '0;
            op2  <= '0;
            id1  <= '0;
            id2  <= '0;
            id3  <= '0;
            t2   <= '0;
            res3 <= '0;
        end else if (en) begin
            v1   <= in_valid;
            op1  <= in_data;
            id1  <= in_id;
            v2   <= v1;
            op2  <= op1;
            id2  <= id1;
            t2   <= t_next;
            v3   <= v2;
            id3  <= id2;
            res3 <= res_next;
        end
    end

    assign out_valid = v3;
    assign out_data  = res3;
    assign out_id    = id3;

endmodule

// File: rtl/barrett_arb_2539.sv
// -----------------------------------------------------------------------------
// barrett_arb_2539
// Round-robin arbiter in front of a shared 3-stage modulo-2539 Barrett
// pipeline. Each residue returns with the index of the requester it came from.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : barrett_arb_2539_if.slave (request and response streams)
//   err_range  : sticky flag, set when an accepted operand is >= 2539^2;
//                only present when BARRETT_ARB_RANGE_CHK_EN is defined
// -----------------------------------------------------------------------------
module barrett_arb_2539
    import barrett_2539_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    barrett_arb_2539_if.slave    bus
`ifdef BARRETT_ARB_RANGE_CHK_EN
    ,
    output logic                 err_range
`endif
);

    logic           en;
    logic           accept;
    logic           found;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] idx;
    int             sum;
    int             nxt;
    operand_t       ops [NREQ];
    operand_t       op_sel;
    logic           v3;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign ops[gi] = bus.req_data[gi*DIN_W +: DIN_W];
    end

    // Global stall: only a held, unconsumed S3 result blocks the pipe.
    assign en = !(v3 && !bus.rsp_ready);

    // First valid requester scanning from ptr upward, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    // Ready is held low during reset even though the empty pipe has en = 1.
    assign accept        = found && en && rst_n;
    assign bus.req_ready = accept ? (NREQ'(1) << g) : '0;
    assign op_sel        = ops[g];

    always_comb begin
        nxt = int'(g) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        ptr_next = IDW'(nxt);
    end

    // Pointer moves past the winner only when its operand is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

`ifdef BARRETT_ARB_RANGE_CHK_EN
    // Out-of-range operands are still reduced; the flag only records them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (accept && (op_sel >= Q_SQ)) begin
            err_range <= 1'b1;
        end
    end
`endif

    barrett_pipe_2539 #(
        .IDW (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (accept),
        .in_data   (op_sel),
        .in_id     (g),
        .out_valid (v3),
        .out_data  (bus.rsp_data),
        .out_id    (bus.rsp_id)
    );

    assign bus.rsp_valid = v3;

endmodule

// File: tb/tb_barrett_arb_2539.sv
// -----------------------------------------------------------------------------
// tb_barrett_arb_2539
// Directed self-checking bench for barrett_arb_2539 (NREQ = 4). Expected
// residues are hand-computed constants. Build with BARRETT_ARB_RANGE_CHK_EN
// defined to also exercise the err_range flag.
// -----------------------------------------------------------------------------
module tb_barrett_arb_2539;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   accepted;

    logic [22:0] vec_op  [4];
    int          vec_exp [4];
    int          res4    [4];

    barrett_arb_2539_if #(.NREQ(4)) bus ();

`ifdef BARRETT_ARB_RANGE_CHK_EN
    logic err_range;
`endif

    barrett_arb_2539 #(
        .NREQ (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BARRETT_ARB_RANGE_CHK_EN
        ,
        .err_range (err_range)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRsp(input string tag, input int id, input int data);
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_id"},    32'(bus.rsp_id),    32'(id));
        checkOutput({tag, "_data"},  32'(bus.rsp_data),  32'(data));
    endtask

    // One cycle: step past the rising edge, then drive.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Single requester streams vec_op back to back; each residue appears two
    // edges after its acceptance edge.
    task automatic runSingle(input int req);
        for (int j = 0; j < 8; j++) begin
            applyStimulus();
            if (j < 4) begin
                bus.req_valid = oh(req);
                bus.req_data[req*23 +: 23] = vec_op[j];
            end else begin
                bus.req_valid = 4'b0000;
            end
            @(negedge clk);
            if (j < 4) checkOutput("single_grant", 32'(bus.req_ready), 32'(oh(req)));
            if (j >= 3 && j < 7) checkRsp("single_rsp", req, vec_exp[j-3]);
            else checkOutput("single_idle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        res4 = '{10, 1, 2461, 2538};

        // Reset state, with requests pending.
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        checkOutput("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef BARRETT_ARB_RANGE_CHK_EN
        checkOutput("rst_err_range", 32'(err_range), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b0000;

        // Requester 0 alone.
        vec_op  = '{23'd100000, 23'd2538, 23'd2539, 23'd5078};
        vec_exp = '{979, 2538, 0, 0};
        runSingle(0);

        // All four requesters; ptr is 1 after the single-requester run.
        applyStimulus();
        bus.req_data  = {23'd6446520, 23'd5000, 23'd2540, 23'd10};
        bus.req_valid = 4'b1111;
        for (int s = 0; s < 12; s++) begin
            if (s > 0) applyStimulus();
            if (s == 8) bus.req_valid = 4'b0000;
            @(negedge clk);
            if (s < 8) checkOutput("rr_grant", 32'(bus.req_ready), 32'(oh((1 + s) % 4)));
            if (s >= 3 && s <= 10) checkRsp("rr_rsp", (s - 2) % 4, res4[(s - 2) % 4]);
            else checkOutput("rr_idle", 32'(bus.rsp_valid), 32'd0);
        end

        // Boundary operands from requester 2.
        vec_op  = '{23'd6446520, 23'd0, 23'd6443982, 23'd12345};
        vec_exp = '{2538, 0, 0, 2189};
        runSingle(2);

        // Backpressure: ptr is 3, so grants go 3,0,1 then the pipe fills.
        applyStimulus();
        bus.req_data  = {23'd6446520, 23'd5000, 23'd2540, 23'd10};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int s = 0; s < 10; s++) begin
            if (s > 0) applyStimulus();
            @(negedge clk);
            accepted += $countones(bus.req_valid & bus.req_ready);
            if (s < 3) begin
                checkOutput("bp_grant", 32'(bus.req_ready), 32'(oh((3 + s) % 4)));
            end else begin
                checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
                checkRsp("bp_hold", 3, 2538);
            end
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd3);
        applyStimulus();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_grant", 32'(bus.req_ready), 32'(oh(2)));
        checkRsp("bp_drain0", 3, 2538);
        applyStimulus();
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checkRsp("bp_drain1", 0, 10);
        applyStimulus();
        @(negedge clk);
        checkRsp("bp_drain2", 1, 1);
        applyStimulus();
        @(negedge clk);
        checkRsp("bp_drain3", 2, 2461);
        applyStimulus();
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.rsp_valid), 32'd0);

        // Oversized operand from requester 0; still answered.
        applyStimulus();
        bus.req_valid = 4'b0001;
        bus.req_data[22:0] = 23'd8388607;
        @(negedge clk);
        checkOutput("big_grant", 32'(bus.req_ready), 32'(oh(0)));
        for (int s = 1; s < 5; s++) begin
            applyStimulus();
            bus.req_valid = 4'b0000;
            @(negedge clk);
            if (s == 3) begin
                checkOutput("big_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                checkOutput("big_rsp_id",    32'(bus.rsp_id),    32'd0);
            end
`ifdef BARRETT_ARB_RANGE_CHK_EN
            checkOutput("err_range_sticky", 32'(err_range), 32'd1);
`endif
        end

        // Reset with three items in flight; ptr is 1 here.
        applyStimulus();
        bus.req_data  = {23'd6446520, 23'd5000, 23'd2540, 23'd10};
        bus.req_valid = 4'b1111;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) applyStimulus();
            @(negedge clk);
            checkOutput("fl_grant", 32'(bus.req_ready), 32'(oh(1 + s)));
        end
        applyStimulus();
        checkOutput("fl_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("fl_id",    32'(bus.rsp_id),    32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_data",  32'(bus.rsp_data),  32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef BARRETT_ARB_RANGE_CHK_EN
        checkOutput("mid_rst_err", 32'(err_range), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_grant", 32'(bus.req_ready), 32'(oh(0)));
        checkOutput("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus();
            @(negedge clk);
            if (s < 2) begin
                checkOutput("post_rst_idle", 32'(bus.rsp_valid), 32'd0);
                checkOutput("post_rst_next", 32'(bus.req_ready), 32'(oh(s + 1)));
            end else begin
                checkRsp("post_rst_rsp", s - 2, res4[s - 2]);
            end
        end
        bus.req_valid = 4'b0000;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
